// File: rtl/fetch_issue_queue_pkg.sv
// Shared definitions for the fetch issue queue: prefix opcode, pairing FSM
// states and the instruction word type (bit 0 is the MSB, [0:5] = opcode).
package fetch_issue_queue_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OPC_W   = 6;

    localparam logic [0:OPC_W-1] OPC_PREFIX = 6'b000001;

    typedef logic [0:INSTR_W-1] instr_t;

    // IDLE: next issue is standalone or a prefix; SUFFIX: next issue completes a pair
    typedef enum logic {
        IDLE   = 1'b0,
        SUFFIX = 1'b1
    } state_e;

    // True when the word's primary opcode marks it as a prefix
    function automatic logic is_prefix(input instr_t word);
        return word[0:OPC_W-1] == OPC_PREFIX;
    endfunction

endpackage

// File: rtl/issue_fifo.sv
// Instruction word FIFO: storage plus head/tail pointers and occupancy count.
// Ports:
//   i_clk, i_rst_n  clock, async active-low reset (pointers/count only)
//   i_clear         synchronous clear of pointers and count
//   i_push, i_data  write i_data at the tail (ignored when full)
//   i_pop           drop the head word (ignored when empty)
//   o_head          word at the head (don't-care when empty)
//   o_count         number of occupied slots
module issue_fifo
    import fetch_issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_clear,
    input  logic                   i_push,
    input  instr_t                 i_data,
    input  logic                   i_pop,
    output instr_t                 o_head,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    instr_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push_ok;
    logic               pop_ok;

    assign push_ok = i_push & ~i_clear & (count_q < CNT_W'(DEPTH));
    assign pop_ok  = i_pop & ~i_clear & (count_q != '0);

    // Storage is not reset; contents are only observed below the count
    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem_q[tail_q] <= i_data;
        end
    end

    // Pointer and count update; DEPTH is a power of two so pointers wrap naturally
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (i_clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop_ok) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign o_head  = mem_q[head_q];
    assign o_count = count_q;

endmodule

// File: rtl/fetch_issue_queue.sv
// Fetch-to-decode issue queue that keeps prefixed instruction pairs together:
// a prefix is only issued once its suffix is queued, and the suffix follows
// on the next issue cycle.
// Ports:
//   i_clk, i_rst_n               clock, async active-low reset
//   i_flush                      drop queue contents and any pending pair
//   i_fetch_valid/i_fetch_instr  word offered by fetch
//   o_fetch_ready                queue has a free slot
//   i_stall                      decoder stall; freezes issue
//   o_en/o_instr/o_suffix        issue strobe, issued word, suffix marker
//   o_count                      occupied slots
module fetch_issue_queue
    import fetch_issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_flush,
    input  logic                   i_fetch_valid,
    input  logic [0:31]            i_fetch_instr,
    output logic                   o_fetch_ready,
    input  logic                   i_stall,
    output logic                   o_en,
    output logic [0:31]            o_instr,
    output logic                   o_suffix,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count;
    instr_t           head;
    logic             push;
    logic             head_pfx;
    logic             en_c;
    logic             suffix_c;

    // Ready depends on registered occupancy only; a same-cycle pop never frees a slot
    assign o_fetch_ready = count < CNT_W'(DEPTH);
    assign push          = i_fetch_valid & o_fetch_ready & ~i_flush;
    assign head_pfx      = is_prefix(head);

    issue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (i_flush),
        .i_push  (push),
        .i_data  (i_fetch_instr),
        .i_pop   (en_c),
        .o_head  (head),
        .o_count (count)
    );

    // Pairing state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a prefix issue arms SUFFIX, the suffix issue returns to IDLE
    always_comb begin
        state_d = state_q;
        if (i_flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (en_c && head_pfx) state_d = SUFFIX;
                SUFFIX:  if (en_c)             state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Issue decision; a lone prefix at the head waits for its suffix
    always_comb begin
        en_c     = 1'b0;
        suffix_c = 1'b0;
        if (!i_stall && !i_flush) begin
            case (state_q)
                IDLE: begin
                    if (head_pfx) begin
                        en_c = count >= CNT_W'(2);
                    end else begin
                        en_c = count >= CNT_W'(1);
                    end
                end
                SUFFIX: begin
                    en_c     = count >= CNT_W'(1);
                    suffix_c = en_c;
                end
                default: begin
                    en_c     = 1'b0;
                    suffix_c = 1'b0;
                end
            endcase
        end
    end

    assign o_en     = en_c;
    assign o_suffix = suffix_c;
    assign o_instr  = head;
    assign o_count  = count;

endmodule

// File: tb/tb_fetch_issue_queue.sv
module tb_fetch_issue_queue;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        fetch_valid;
    logic [0:31] fetch_instr;
    logic        fetch_ready;
    logic        stall;
    logic        en;
    logic [0:31] instr;
    logic        suffix;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_issue_queue #(.DEPTH(4)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_flush       (flush),
        .i_fetch_valid (fetch_valid),
        .i_fetch_instr (fetch_instr),
        .o_fetch_ready (fetch_ready),
        .i_stall       (stall),
        .o_en          (en),
        .o_instr       (instr),
        .o_suffix      (suffix),
        .o_count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] win;
        logic        stall;
        logic        flush;
        logic        en;
        logic        sfx;
        logic [31:0] wout;
        logic [2:0]  cnt;
        logic        rdy;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic v, logic [31:0] wi, logic st, logic fl,
                                logic e, logic sf, logic [31:0] wo, logic [2:0] c, logic r);
        vec_t x;
        x.valid = v; x.win = wi; x.stall = st; x.flush = fl;
        x.en = e; x.sfx = sf; x.wout = wo; x.cnt = c; x.rdy = r;
        vecs.push_back(x);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge; outputs settle 1 time unit later
    task automatic apply(input logic v, input logic [31:0] wi, input logic st, input logic fl);
        @(negedge clk);
        fetch_valid = v;
        fetch_instr = wi;
        stall       = st;
        flush       = fl;
        #1;
    endtask

    task automatic expect_out(input string tag, input logic e, input logic sf,
                              input logic [31:0] wo, input logic [2:0] c, input logic r);
        chk({tag, ".en"},    32'(en),          32'(e));
        chk({tag, ".sfx"},   32'(suffix),      32'(sf));
        chk({tag, ".count"}, 32'(count),       32'(c));
        chk({tag, ".ready"}, 32'(fetch_ready), 32'(r));
        if (e) chk({tag, ".instr"}, instr, wo);
    endtask

    // Reference model: a plain word queue plus a "pair in progress" flag
    logic [31:0] mq[$];
    bit          m_pair;

    function automatic bit pfx(logic [31:0] w);
        return w[31:26] == 6'b000001;
    endfunction

    initial begin
        logic        v, st, fl, e_en, e_sf;
        logic [31:0] w, hd;
        int          sz;

        rst_n = 1'b0; flush = 1'b0; fetch_valid = 1'b0; fetch_instr = '0; stall = 1'b0;
        #2;
        expect_out("reset", 1'b0, 1'b0, 32'h0, 3'd0, 1'b1);
        #10 rst_n = 1'b1;

        // Standalone flow
        add(1, 32'h48000010, 0, 0,  0, 0, 32'h0,        3'd0, 1);
        add(1, 32'h4E800020, 0, 0,  1, 0, 32'h48000010, 3'd1, 1);
        add(0, 32'h0,        0, 0,  1, 0, 32'h4E800020, 3'd1, 1);
        add(0, 32'h0,        0, 0,  0, 0, 32'h0,        3'd0, 1);
        // Prefix waits for its suffix
        add(1, 32'h04000000, 0, 0,  0, 0, 32'h0,        3'd0, 1);
        add(0, 32'h0,        0, 0,  0, 0, 32'h0,        3'd1, 1);
        add(0, 32'h0,        0, 0,  0, 0, 32'h0,        3'd1, 1);
        add(0, 32'h0,        0, 0,  0, 0, 32'h0,        3'd1, 1);
        add(1, 32'h38600001, 0, 0,  0, 0, 32'h0,        3'd1, 1);
        add(0, 32'h0,        0, 0,  1, 0, 32'h04000000, 3'd2, 1);
        add(0, 32'h0,        0, 0,  1, 1, 32'h38600001, 3'd1, 1);
        add(0, 32'h0,        0, 0,  0, 0, 32'h0,        3'd0, 1);
        // Fill under stall; fifth word refused
        add(1, 32'hA0000001, 1, 0,  0, 0, 32'h0,        3'd0, 1);
        add(1, 32'hA0000002, 1, 0,  0, 0, 32'h0,        3'd1, 1);
        add(1, 32'hA0000003, 1, 0,  0, 0, 32'h0,        3'd2, 1);
        add(1, 32'hA0000004, 1, 0,  0, 0, 32'h0,        3'd3, 1);
        add(1, 32'hA0000005, 1, 0,  0, 0, 32'h0,        3'd4, 0);
        add(0, 32'h0,        0, 0,  1, 0, 32'hA0000001, 3'd4, 0);
        add(0, 32'h0,        0, 0,  1, 0, 32'hA0000002, 3'd3, 1);
        add(0, 32'h0,        0, 0,  1, 0, 32'hA0000003, 3'd2, 1);
        add(0, 32'h0,        0, 0,  1, 0, 32'hA0000004, 3'd1, 1);
        add(0, 32'h0,        0, 0,  0, 0, 32'h0,        3'd0, 1);

        foreach (vecs[i]) begin
            apply(vecs[i].valid, vecs[i].win, vecs[i].stall, vecs[i].flush);
            expect_out($sformatf("vec%0d", i), vecs[i].en, vecs[i].sfx, vecs[i].wout,
                       vecs[i].cnt, vecs[i].rdy);
        end

        // Stall between prefix and suffix
        apply(1, 32'h04000000, 0, 0); expect_out("stl0", 0, 0, 32'h0,        3'd0, 1);
        apply(1, 32'h38600001, 0, 0); expect_out("stl1", 0, 0, 32'h0,        3'd1, 1);
        apply(0, 32'h0,        0, 0); expect_out("stl2", 1, 0, 32'h04000000, 3'd2, 1);
        apply(0, 32'h0,        1, 0); expect_out("stl3", 0, 0, 32'h0,        3'd1, 1);
        apply(0, 32'h0,        1, 0); expect_out("stl4", 0, 0, 32'h0,        3'd1, 1);
        apply(0, 32'h0,        0, 0); expect_out("stl5", 1, 1, 32'h38600001, 3'd1, 1);
        apply(0, 32'h0,        0, 0); expect_out("stl6", 0, 0, 32'h0,        3'd0, 1);

        // Flush (with stall also high) after the prefix issued
        apply(1, 32'h04000000, 0, 0); expect_out("fl0", 0, 0, 32'h0,        3'd0, 1);
        apply(1, 32'h38600001, 0, 0); expect_out("fl1", 0, 0, 32'h0,        3'd1, 1);
        apply(0, 32'h0,        0, 0); expect_out("fl2", 1, 0, 32'h04000000, 3'd2, 1);
        apply(1, 32'h7C000001, 1, 1); expect_out("fl3", 0, 0, 32'h0,        3'd1, 1);
        apply(0, 32'h0,        0, 0); expect_out("fl4", 0, 0, 32'h0,        3'd0, 1);
        apply(1, 32'h48000010, 0, 0); expect_out("fl5", 0, 0, 32'h0,        3'd0, 1);
        apply(0, 32'h0,        0, 0); expect_out("fl6", 1, 0, 32'h48000010, 3'd1, 1);
        apply(0, 32'h0,        0, 0); expect_out("fl7", 0, 0, 32'h0,        3'd0, 1);

        // Asynchronous reset with three words queued
        apply(1, 32'hA0000001, 1, 0);
        apply(1, 32'hA0000002, 1, 0);
        apply(1, 32'hA0000003, 1, 0);
        apply(0, 32'h0,        1, 0); expect_out("rs0", 0, 0, 32'h0, 3'd3, 1);
        #2 rst_n = 1'b0; stall = 1'b0;
        #1 expect_out("rs1", 0, 0, 32'h0, 3'd0, 1);
        @(negedge clk); rst_n = 1'b1;
        #1 expect_out("rs2", 0, 0, 32'h0, 3'd0, 1);

        // Reset inside a pair abandons the suffix
        apply(1, 32'h04000000, 0, 0); expect_out("rp0", 0, 0, 32'h0,        3'd0, 1);
        apply(1, 32'h38600001, 0, 0); expect_out("rp1", 0, 0, 32'h0,        3'd1, 1);
        apply(0, 32'h0,        0, 0); expect_out("rp2", 1, 0, 32'h04000000, 3'd2, 1);
        apply(0, 32'h0,        1, 0); expect_out("rp3", 0, 0, 32'h0,        3'd1, 1);
        #2 rst_n = 1'b0;
        #1 expect_out("rp4", 0, 0, 32'h0, 3'd0, 1);
        @(negedge clk); rst_n = 1'b1;
        apply(1, 32'h48000010, 0, 0); expect_out("rp5", 0, 0, 32'h0,        3'd0, 1);
        apply(0, 32'h0,        0, 0); expect_out("rp6", 1, 0, 32'h48000010, 3'd1, 1);
        apply(0, 32'h0,        0, 0); expect_out("rp7", 0, 0, 32'h0,        3'd0, 1);

        // Randomized traffic against the reference model
        mq.delete();
        m_pair = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            v  = $urandom_range(0, 9) < 6;
            w  = ($urandom_range(0, 3) == 0) ? {6'b000001, 26'($urandom)} : 32'($urandom);
            st = $urandom_range(0, 4) == 0;
            fl = $urandom_range(0, 49) == 0;
            apply(v, w, st, fl);

            sz   = mq.size();
            hd   = (sz > 0) ? mq[0] : 32'h0;
            e_en = 1'b0;
            if (!fl && !st && sz > 0) begin
                if (m_pair)       e_en = 1'b1;
                else if (pfx(hd)) e_en = sz >= 2;
                else              e_en = 1'b1;
            end
            e_sf = e_en & m_pair;
            expect_out("rnd", e_en, e_sf, hd, 3'(sz), sz < 4);

            if (fl) begin
                mq.delete();
                m_pair = 1'b0;
            end else begin
                if (e_en) begin
                    void'(mq.pop_front());
                    m_pair = m_pair ? 1'b0 : pfx(hd);
                end
                if (v && sz < 4) mq.push_back(w);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
